// File: rtl/fx2_slave_fifo_ctrl_if.sv
// FX2 slave-FIFO flag and strobe pins; the data bus stays a separate inout port.
interface fx2_slave_fifo_ctrl_if;
  logic       USB_FLAGA;
  logic       USB_FLAGD;
  logic [1:0] USB_ADDR;
  logic       USB_SLOE;
  logic       USB_SLRD;
  logic       USB_SLWR;
  logic       USB_PKEND;

  modport master (
    input  USB_FLAGA, USB_FLAGD,
    output USB_ADDR, USB_SLOE, USB_SLRD, USB_SLWR, USB_PKEND
  );

  modport slave (
    output USB_FLAGA, USB_FLAGD,
    input  USB_ADDR, USB_SLOE, USB_SLRD, USB_SLWR, USB_PKEND
  );
endinterface

// File: rtl/fx2_slave_fifo_ctrl.sv
// FX2 synchronous slave-FIFO master: EP2->EP6 loopback through a local buffer,
// or an incrementing pattern stream to EP6, with PKEND commit of idle partial packets.
module fx2_slave_fifo_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                  USB_IFCLK,
  input  logic                  RST_N,
  input  logic                  MODE,
  fx2_slave_fifo_ctrl_if.master usb,
  inout  wire  [DATA_W-1:0]     USB_DATA,
  output logic [3:0]            LED
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_SETUP = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_RD_END   = 3'd3;
  localparam logic [2:0] S_WR_SETUP = 3'd4;
  localparam logic [2:0] S_WRITE    = 3'd5;
  localparam logic [2:0] S_PKEND    = 3'd6;

  logic              r_rst_meta;
  logic              r_rst_sync;
  logic [2:0]        r_state;
  logic              r_mode;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_pat;
  logic [PW-1:0]     r_pkt_cnt;
  logic [TW-1:0]     r_tmo;
  logic              r_tmo_pend;
  logic              r_led3;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_pkt_last;
  logic              w_drive;
  logic [DATA_W-1:0] w_dout;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge USB_IFCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_rd_fire  = (r_state == S_READ) && usb.USB_FLAGA && !w_full;
  assign w_wr_fire  = (r_state == S_WRITE) && usb.USB_FLAGD && (r_mode || !w_empty);
  assign w_pkt_last = (r_pkt_cnt == PW'(PKT_WORDS - 1));
  assign w_drive    = (r_state == S_WR_SETUP) || (r_state == S_WRITE) || (r_state == S_PKEND);
  assign w_dout     = r_mode ? r_pat : r_mem[r_rptr];

  assign USB_DATA       = w_drive ? w_dout : 'z;
  assign usb.USB_ADDR   = w_drive ? 2'b10 : 2'b00;
  assign usb.USB_SLOE   = !((r_state == S_RD_SETUP) || (r_state == S_READ));
  assign usb.USB_SLRD   = !w_rd_fire;
  assign usb.USB_SLWR   = !w_wr_fire;
  assign usb.USB_PKEND  = (r_state != S_PKEND);
  assign LED            = {r_led3, w_full, (r_state == S_WRITE), (r_state == S_READ)};

  always_ff @(posedge USB_IFCLK) begin
    if (w_rd_fire) r_mem[r_wptr] <= USB_DATA;
  end

  always_ff @(posedge USB_IFCLK or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_pat      <= '0;
      r_pkt_cnt  <= '0;
      r_tmo      <= '0;
      r_tmo_pend <= 1'b0;
      r_led3     <= 1'b0;
    end else begin
      if (w_rd_fire) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= r_count + 1'b1;
      end else if (w_wr_fire) begin
        if (r_mode) begin
          r_pat <= r_pat + 1'b1;
        end else begin
          r_rptr  <= r_rptr + 1'b1;
          r_count <= r_count - 1'b1;
        end
        r_pkt_cnt <= w_pkt_last ? '0 : r_pkt_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_mode <= MODE;
          r_tmo  <= '0;
          if (!MODE && usb.USB_FLAGA && !w_full) begin
            r_state <= S_RD_SETUP;
          end else if ((!w_empty || MODE) && usb.USB_FLAGD) begin
            r_state <= S_WR_SETUP;
          end else if ((r_pkt_cnt != '0) && w_empty) begin
            // The timeout path reuses WR_SETUP so the bus turns around before PKEND.
            if (r_tmo == TW'(TIMEOUT - 1)) begin
              r_tmo_pend <= 1'b1;
              r_state    <= S_WR_SETUP;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        S_RD_SETUP: r_state <= S_READ;
        S_READ: begin
          if (!w_rd_fire || (r_count == CW'(DEPTH - 1))) r_state <= S_RD_END;
        end
        S_RD_END:   r_state <= S_IDLE;
        S_WR_SETUP: r_state <= r_tmo_pend ? S_PKEND : S_WRITE;
        S_WRITE: begin
          if (!w_wr_fire || (r_mode ? w_pkt_last : (r_count == CW'(1)))) r_state <= S_IDLE;
        end
        S_PKEND: begin
          r_pkt_cnt  <= '0;
          r_tmo      <= '0;
          r_tmo_pend <= 1'b0;
          r_led3     <= !r_led3;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fx2_slave_fifo_ctrl.sv
// Directed bench: FX2 endpoint model (EP2 source, EP6 sink) with pin-protocol monitors.
`timescale 1ns/1ps
module tb_fx2_slave_fifo_ctrl;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 64;
  localparam int PKT_WORDS = 256;
  localparam int TIMEOUT   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic [3:0]        led;
  wire  [DATA_W-1:0] usb_data;
  logic [DATA_W-1:0] ep2_head;

  fx2_slave_fifo_ctrl_if usb_if ();

  fx2_slave_fifo_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PKT_WORDS (PKT_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .USB_IFCLK (clk),
    .RST_N     (rst_n),
    .MODE      (mode),
    .usb       (usb_if),
    .USB_DATA  (usb_data),
    .LED       (led)
  );

  always #5 clk = ~clk;

  assign usb_data = usb_if.USB_SLOE ? 'z : ep2_head;

  logic [DATA_W-1:0] ep2_q[$];
  logic [DATA_W-1:0] ep6_q[$];
  int cyc, rd_cnt, pk_cnt, last_wr_cyc, pk_cyc;
  int v_drive, v_addr, v_hold, v_m1;
  int hold_left, hold_sz;
  logic hold_req, hold_done, flagd_en;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ep6_at(input int i);
    if (i < ep6_q.size()) return 32'(ep6_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // FX2 side: decide at negedge what the coming edge transfers, apply just after it.
  initial begin : fx2_model
    logic rd_f, wr_f, pk_f, strobe, prev_strobe;
    logic [1:0] prev_addr;
    logic [DATA_W-1:0] wd;
    cyc = 0; rd_cnt = 0; pk_cnt = 0; last_wr_cyc = 0; pk_cyc = 0;
    v_drive = 0; v_addr = 0; v_hold = 0; v_m1 = 0;
    hold_left = 0; hold_sz = 0; hold_done = 1'b0;
    prev_strobe = 1'b0; prev_addr = 2'b00;
    usb_if.USB_FLAGA = 1'b0;
    usb_if.USB_FLAGD = 1'b0;
    ep2_head = '0;
    forever begin
      @(negedge clk);
      rd_f   = !usb_if.USB_SLRD && usb_if.USB_FLAGA;
      wr_f   = !usb_if.USB_SLWR && usb_if.USB_FLAGD;
      pk_f   = !usb_if.USB_PKEND;
      wd     = usb_data;
      strobe = !usb_if.USB_SLRD || !usb_if.USB_SLWR;
      if (!usb_if.USB_SLOE && dut.w_drive) v_drive++;
      if (strobe && prev_strobe && (usb_if.USB_ADDR != prev_addr)) v_addr++;
      if (!usb_if.USB_SLRD && (usb_if.USB_ADDR != 2'b00)) v_addr++;
      if (!usb_if.USB_SLWR && (usb_if.USB_ADDR != 2'b10)) v_addr++;
      if (!usb_if.USB_FLAGD && !usb_if.USB_SLWR) v_hold++;
      if (mode && (!usb_if.USB_SLOE || !usb_if.USB_SLRD)) v_m1++;
      prev_strobe = strobe;
      prev_addr   = usb_if.USB_ADDR;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        ep6_q.delete();
        rd_cnt = 0; pk_cnt = 0; last_wr_cyc = 0; pk_cyc = 0;
      end else begin
        if (rd_f && (ep2_q.size() != 0)) begin
          void'(ep2_q.pop_front());
          rd_cnt++;
        end
        if (wr_f) begin
          ep6_q.push_back(wd);
          last_wr_cyc = cyc;
        end
        if (pk_f) begin
          pk_cnt++;
          pk_cyc = cyc;
        end
      end
      if (hold_left != 0) begin
        hold_left--;
        if (hold_left == 0) hold_sz = ep6_q.size();
      end else if (hold_req && !hold_done && (ep6_q.size() == 10)) begin
        hold_done = 1'b1;
        hold_left = 20;
      end
      usb_if.USB_FLAGA = (ep2_q.size() != 0);
      ep2_head         = (ep2_q.size() != 0) ? ep2_q[0] : '0;
      usb_if.USB_FLAGD = flagd_en && (hold_left == 0);
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; mode = 1'b0; flagd_en = 1'b0; hold_req = 1'b0;
    ep2_q.delete();
    run(3);
    rst_n = 1'b1;
    run(4);
  endtask

  task automatic load_ep2(input int n);
    for (int i = 0; i < n; i++) ep2_q.push_back(DATA_W'(i));
  endtask

  task automatic wait_ep6(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ep6_q.size() >= n) break;
      run(1);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0; mode = 1'b0; flagd_en = 1'b0; hold_req = 1'b0;
    run(3);
    check("rst_addr",  32'(usb_if.USB_ADDR),  32'd0);
    check("rst_sloe",  32'(usb_if.USB_SLOE),  32'd1);
    check("rst_slrd",  32'(usb_if.USB_SLRD),  32'd1);
    check("rst_slwr",  32'(usb_if.USB_SLWR),  32'd1);
    check("rst_pkend", 32'(usb_if.USB_PKEND), 32'd1);
    check("rst_led",   32'(led),              32'd0);
    check("rst_drive", 32'(dut.w_drive),      32'd0);
    rst_n = 1'b1;
    run(4);

    // Full 256-word packet: auto-committed, no PKEND expected.
    do_reset();
    flagd_en = 1'b1;
    load_ep2(256);
    wait_ep6(256, 5000);
    run(TIMEOUT + 30);
    check("t1_count", 32'(ep6_q.size()), 32'd256);
    for (int i = 0; i < 256; i++) check("t1_word", ep6_at(i), 32'(i));
    check("t1_pkend", 32'(pk_cnt), 32'd0);

    // 100-word partial packet: single PKEND TIMEOUT+2 edges after the last write.
    do_reset();
    flagd_en = 1'b1;
    load_ep2(100);
    wait_ep6(100, 3000);
    run(TIMEOUT + 30);
    check("t2_count", 32'(ep6_q.size()), 32'd100);
    for (int i = 0; i < 100; i++) check("t2_word", ep6_at(i), 32'(i));
    check("t2_pkend_cnt", 32'(pk_cnt), 32'd1);
    check("t2_pkend_delay", 32'(pk_cyc - last_wr_cyc), 32'(TIMEOUT + 2));
    check("t2_led3", 32'(led[3]), 32'd1);

    // EP6 back-pressure: FLAGD low for 20 cycles after the 10th word.
    do_reset();
    flagd_en = 1'b1;
    hold_req = 1'b1;
    load_ep2(40);
    wait_ep6(40, 3000);
    run(TIMEOUT + 30);
    check("t3_hold_seen", 32'(hold_done), 32'd1);
    check("t3_hold_size", 32'(hold_sz), 32'd10);
    check("t3_slwr_hold", 32'(v_hold), 32'd0);
    check("t3_count", 32'(ep6_q.size()), 32'd40);
    for (int i = 0; i < 40; i++) check("t3_word", ep6_at(i), 32'(i));
    check("t3_pkend_cnt", 32'(pk_cnt), 32'd1);

    // Pattern mode: incrementing stream, FX2 read side untouched.
    do_reset();
    mode = 1'b1;
    flagd_en = 1'b1;
    wait_ep6(256, 2000);
    flagd_en = 1'b0;
    run(2);
    check("t4_count_min", 32'(ep6_q.size() >= 256), 32'd1);
    for (int i = 0; i < 256; i++) check("t4_word", ep6_at(i), 32'(i));
    check("t4_sloe_slrd", 32'(v_m1), 32'd0);

    // Reset in the middle of a read burst.
    do_reset();
    flagd_en = 1'b1;
    load_ep2(60);
    for (int i = 0; i < 500; i++) begin
      if (rd_cnt >= 30) break;
      run(1);
    end
    check("t5_rd_cnt", 32'(rd_cnt), 32'd30);
    check("t5_led_read", 32'(led[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_slrd",  32'(usb_if.USB_SLRD),  32'd1);
    check("t5_slwr",  32'(usb_if.USB_SLWR),  32'd1);
    check("t5_sloe",  32'(usb_if.USB_SLOE),  32'd1);
    check("t5_pkend", 32'(usb_if.USB_PKEND), 32'd1);
    ep2_q.delete();
    run(3);
    rst_n = 1'b1;
    run(20);
    check("t5_no_writes", 32'(ep6_q.size()), 32'd0);
    check("t5_count",     32'(dut.r_count),  32'd0);
    check("t5_state",     32'(dut.r_state),  32'd0);
    check("t5_led",       32'(led),          32'd0);

    check("bus_drive_sloe", 32'(v_drive), 32'd0);
    check("addr_stable",    32'(v_addr),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
